dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 210 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word load-store slave with configurable wait states.
// Optional macro DMEM_RESPONDER_MISALIGN_TRAP_EN faults misaligned SH/SW instead of aligning them.
module dmem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        dmem_req,
   input  logic        dmem_wr_en,
   input  logic [1:0]  dmem_size,
   input  logic        dmem_zero_ext,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wr_data,
   output logic [31:0] dmem_rd_data,
   output logic        dmem_ready,
   output logic        dmem_fault
);

   localparam int   AW      = $clog2(DEPTH_WORDS);
   localparam logic NO_WAIT = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q;
   logic [3:0]  cnt_q;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        wr_en_q;
   logic        zext_q;
   logic [31:0] wdata_q;
   logic [31:0] rd_data_q;
   logic        ready_q;
   logic        fault_q;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic [31:0]   a_addr_s;
   logic [1:0]    a_size_s;
   logic          a_we_s;
   logic          a_zext_s;
   logic [31:0]   a_wdata_s;
   logic          fault_s;
   logic [31:0]   eff_addr_s;
   logic [AW-1:0] idx_s;
   logic [1:0]    off_s;
   logic [31:0]   word_s;
   logic [31:0]   shifted_s;
   logic [31:0]   rd_data_d;
   logic [3:0]    be_s;
   logic [31:0]   wlane_s;
   logic          complete_s;
   logic          mem_we_s;
   logic          unused_s;

   // Decode the access being completed: latched fields while waiting, live inputs otherwise
   always_comb begin
      a_addr_s   = dmem_addr;
      a_size_s   = dmem_size;
      a_we_s     = dmem_wr_en;
      a_zext_s   = dmem_zero_ext;
      a_wdata_s  = dmem_wr_data;
      if (state_q == ST_WAIT) begin
         a_addr_s  = addr_q;
         a_size_s  = size_q;
         a_we_s    = wr_en_q;
         a_zext_s  = zext_q;
         a_wdata_s = wdata_q;
      end else begin
         a_addr_s  = dmem_addr;
      end

      fault_s    = (a_size_s == 2'b11);
      eff_addr_s = a_addr_s;
`ifdef DMEM_RESPONDER_MISALIGN_TRAP_EN
      case (a_size_s)
         2'b01:   fault_s = a_addr_s[0];
         2'b10:   fault_s = (a_addr_s[1:0] != 2'b00);
         2'b11:   fault_s = 1'b1;
         default: fault_s = 1'b0;
      endcase
`else
      // Misaligned halves/words silently drop to natural alignment
      case (a_size_s)
         2'b01:   eff_addr_s = {a_addr_s[31:1], 1'b0};
         2'b10:   eff_addr_s = {a_addr_s[31:2], 2'b00};
         default: eff_addr_s = a_addr_s;
      endcase
`endif

      idx_s     = eff_addr_s[AW+1:2];
      off_s     = eff_addr_s[1:0];
      word_s    = mem_q[idx_s];
      shifted_s = word_s >> {off_s, 3'b000};

      if (fault_s || a_we_s) begin
         rd_data_d = 32'd0;
      end else begin
         case (a_size_s)
            2'b00:   rd_data_d = a_zext_s ? {24'd0, shifted_s[7:0]}
                                          : {{24{shifted_s[7]}}, shifted_s[7:0]};
            2'b01:   rd_data_d = a_zext_s ? {16'd0, shifted_s[15:0]}
                                          : {{16{shifted_s[15]}}, shifted_s[15:0]};
            2'b10:   rd_data_d = word_s;
            default: rd_data_d = 32'd0;
         endcase
      end

      case (a_size_s)
         2'b00: begin
            be_s    = 4'b0001 << off_s;
            wlane_s = {4{a_wdata_s[7:0]}};
         end
         2'b01: begin
            be_s    = 4'b0011 << off_s;
            wlane_s = {2{a_wdata_s[15:0]}};
         end
         2'b10: begin
            be_s    = 4'b1111;
            wlane_s = a_wdata_s;
         end
         default: begin
            be_s    = 4'b0000;
            wlane_s = 32'd0;
         end
      endcase

      complete_s = ((state_q == ST_WAIT) && (cnt_q == 4'd0)) ||
                   (NO_WAIT && dmem_req && (state_q != ST_WAIT));
      mem_we_s   = complete_s && a_we_s && !fault_s;
      unused_s   = ^{eff_addr_s};
   end

   // Memory array: byte-lane writes on the completing edge, never reset
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
               mem_q[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
            end
         end
      end
   end

   // Access FSM with registered response outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= 4'd0;
         addr_q    <= 32'd0;
         size_q    <= 2'b00;
         wr_en_q   <= 1'b0;
         zext_q    <= 1'b0;
         wdata_q   <= 32'd0;
         rd_data_q <= 32'd0;
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         ready_q   <= 1'b0;
         fault_q   <= 1'b0;
         rd_data_q <= 32'd0;
         case (state_q)
            ST_IDLE, ST_RESP: begin
               if (dmem_req) begin
                  addr_q  <= dmem_addr;
                  size_q  <= dmem_size;
                  wr_en_q <= dmem_wr_en;
                  zext_q  <= dmem_zero_ext;
                  wdata_q <= dmem_wr_data;
                  if (NO_WAIT) begin
                     state_q   <= ST_RESP;
                     ready_q   <= 1'b1;
                     fault_q   <= fault_s;
                     rd_data_q <= rd_data_d;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= 4'(WAIT_CYCLES);
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               // New requests are deliberately ignored here; nothing is queued
               if (cnt_q == 4'd0) begin
                  state_q   <= ST_RESP;
                  ready_q   <= 1'b1;
                  fault_q   <= fault_s;
                  rd_data_q <= rd_data_d;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= 4'd0;
            end
         endcase
      end
   end

   assign dmem_rd_data = rd_data_q;
   assign dmem_ready   = ready_q;
   assign dmem_fault   = fault_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: zero-wait, 3-wait and 2-wait (reset abort) instances.
module tb_dmem_responder;

   logic        clk;
   logic        reset_n;
   logic        req0, req3, req2;
   logic        wr_en;
   logic [1:0]  size;
   logic        zext;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rd0, rd3, rd2;
   logic        rdy0, rdy3, rdy2;
   logic        flt0, flt3, flt2;

   int checks = 0;
   int errors = 0;

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .reset_n(reset_n), .dmem_req(req0), .dmem_wr_en(wr_en),
      .dmem_size(size), .dmem_zero_ext(zext), .dmem_addr(addr), .dmem_wr_data(wdata),
      .dmem_rd_data(rd0), .dmem_ready(rdy0), .dmem_fault(flt0));

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u_w3 (
      .clk(clk), .reset_n(reset_n), .dmem_req(req3), .dmem_wr_en(wr_en),
      .dmem_size(size), .dmem_zero_ext(zext), .dmem_addr(addr), .dmem_wr_data(wdata),
      .dmem_rd_data(rd3), .dmem_ready(rdy3), .dmem_fault(flt3));

   dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_w2 (
      .clk(clk), .reset_n(reset_n), .dmem_req(req2), .dmem_wr_en(wr_en),
      .dmem_size(size), .dmem_zero_ext(zext), .dmem_addr(addr), .dmem_wr_data(wdata),
      .dmem_rd_data(rd2), .dmem_ready(rdy2), .dmem_fault(flt2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One zero-wait access; ready must be high right after the accepting edge
   task automatic acc0(input string tag, input logic we, input logic [1:0] sz, input logic zx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_flt);
      @(negedge clk);
      req0 = 1'b1; wr_en = we; size = sz; zext = zx; addr = a; wdata = wd;
      @(posedge clk); #1;
      check_eq({tag, "_rdy"}, 32'(rdy0), 32'd1);
      check_eq({tag, "_rd"}, rd0, exp_rd);
      check_eq({tag, "_flt"}, 32'(flt0), 32'(exp_flt));
   endtask

   task automatic idle0(input string tag);
      @(negedge clk);
      req0 = 1'b0;
      @(posedge clk); #1;
      check_eq({tag, "_rdy"}, 32'(rdy0), 32'd0);
      check_eq({tag, "_rd"}, rd0, 32'd0);
      check_eq({tag, "_flt"}, 32'(flt0), 32'd0);
   endtask

   task automatic set_req(input int sel, input logic v);
      if (sel == 3) req3 = v;
      else req2 = v;
   endtask

   function automatic logic get_rdy(input int sel);
      return (sel == 3) ? rdy3 : rdy2;
   endfunction

   function automatic logic [31:0] get_rd(input int sel);
      return (sel == 3) ? rd3 : rd2;
   endfunction

   // Access on a waiting instance; reports the cycle index of the ready pulse and pulse count
   task automatic slow_acc(input int sel, input bit now, input logic we, input logic [1:0] sz,
                           input logic [31:0] a, input logic [31:0] wd, input bit pulse,
                           output int rise_k, output int pulses, output logic [31:0] rd_at);
      if (!now) @(negedge clk);
      wr_en = we; size = sz; zext = 1'b0; addr = a; wdata = wd;
      set_req(sel, 1'b1);
      @(posedge clk); #1;
      rise_k = -1; pulses = 0; rd_at = 32'd0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         set_req(sel, (pulse && k <= 3) ? 1'b1 : 1'b0);
         @(posedge clk); #1;
         if (get_rdy(sel)) begin
            pulses++;
            if (rise_k < 0) begin
               rise_k = k;
               rd_at  = get_rd(sel);
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int rk, np;
      logic [31:0] rdv;
      reset_n = 1'b0; req0 = 1'b0; req3 = 1'b0; req2 = 1'b0;
      wr_en = 1'b0; size = 2'b00; zext = 1'b0; addr = 32'd0; wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_rdy", 32'(rdy0), 32'd0);
      check_eq("rst_rd", rd0, 32'd0);
      check_eq("rst_flt", 32'(flt0), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Zero-wait: back-to-back store then load
      acc0("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0);
      acc0("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0);
      acc0("sw10z", 1'b1, 2'b10, 1'b0, 32'h10, 32'd0, 32'd0, 1'b0);
      acc0("sb13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h80, 32'd0, 1'b0);
      acc0("lb13", 1'b0, 2'b00, 1'b0, 32'h13, 32'd0, 32'hFFFFFF80, 1'b0);
      acc0("lbu13", 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 32'h00000080, 1'b0);
      acc0("lh12", 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'hFFFF8000, 1'b0);

      acc0("sw04", 1'b1, 2'b10, 1'b0, 32'h04, 32'h12345678, 32'd0, 1'b0);
`ifdef DMEM_RESPONDER_MISALIGN_TRAP_EN
      acc0("sw06", 1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF, 32'd0, 1'b1);
      acc0("lw04", 1'b0, 2'b10, 1'b0, 32'h04, 32'd0, 32'h12345678, 1'b0);
`else
      acc0("sw06", 1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF, 32'd0, 1'b0);
      acc0("lw04", 1'b0, 2'b10, 1'b0, 32'h04, 32'd0, 32'hFFFFFFFF, 1'b0);
`endif

      // Address wrap and illegal size
      acc0("sw1000", 1'b1, 2'b10, 1'b0, 32'h1000, 32'hA5A5A5A5, 32'd0, 1'b0);
      acc0("lw00", 1'b0, 2'b10, 1'b0, 32'h0, 32'd0, 32'hA5A5A5A5, 1'b0);
      acc0("ld_sz3", 1'b0, 2'b11, 1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
      acc0("st_sz3", 1'b1, 2'b11, 1'b0, 32'h0, 32'h0, 32'd0, 1'b1);
      acc0("lw00b", 1'b0, 2'b10, 1'b0, 32'h0, 32'd0, 32'hA5A5A5A5, 1'b0);

      // Halfword/byte lanes
      acc0("sh00", 1'b1, 2'b01, 1'b0, 32'h0, 32'h1234BEEF, 32'd0, 1'b0);
      acc0("lh02", 1'b0, 2'b01, 1'b0, 32'h2, 32'd0, 32'hFFFFA5A5, 1'b0);
      acc0("lhu00", 1'b0, 2'b01, 1'b1, 32'h0, 32'd0, 32'h0000BEEF, 1'b0);
      acc0("sb01", 1'b1, 2'b00, 1'b0, 32'h1, 32'h77, 32'd0, 1'b0);
      acc0("lw00c", 1'b0, 2'b10, 1'b0, 32'h0, 32'd0, 32'hA5A577EF, 1'b0);
      idle0("idle0");

      // Three wait cycles with ignored requests during WAIT
      slow_acc(3, 1'b0, 1'b1, 2'b10, 32'h10, 32'h0BADF00D, 1'b1, rk, np, rdv);
      check_eq("w3_sw_rise", 32'(rk), 32'd4);
      check_eq("w3_sw_pulses", 32'(np), 32'd1);
      check_eq("w3_sw_rd", rdv, 32'd0);
      slow_acc(3, 1'b0, 1'b0, 2'b10, 32'h10, 32'd0, 1'b1, rk, np, rdv);
      check_eq("w3_lw_rise", 32'(rk), 32'd4);
      check_eq("w3_lw_pulses", 32'(np), 32'd1);
      check_eq("w3_lw_rd", rdv, 32'h0BADF00D);

      // Two wait cycles; store aborted by reset must never land
      slow_acc(2, 1'b0, 1'b1, 2'b10, 32'h20, 32'h55, 1'b0, rk, np, rdv);
      check_eq("w2_sw_rise", 32'(rk), 32'd3);
      check_eq("w2_sw_pulses", 32'(np), 32'd1);
      @(negedge clk);
      wr_en = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'h1; req2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req2 = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      check_eq("w2_rst_rdy", 32'(rdy2), 32'd0);
      check_eq("w2_rst_flt", 32'(flt2), 32'd0);
      check_eq("w2_rst_rd", rd2, 32'd0);
      np = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (k == 2) reset_n = 1'b1;
         if (rdy2) np++;
      end
      check_eq("w2_abort_pulses", 32'(np), 32'd0);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      slow_acc(2, 1'b1, 1'b0, 2'b10, 32'h20, 32'd0, 1'b0, rk, np, rdv);
      check_eq("w2_lw_rise", 32'(rk), 32'd3);
      check_eq("w2_lw_rd", rdv, 32'h55);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
